dff: RTL and testbench



---
 rtl/dff_pkg.sv | 13 +
 rtl/dff.sv | 74 +++++++
 tb/tb_dff.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dff_pkg.sv
// Shared constants for the dff storage primitive and its callers.
package dff_pkg;

    // Control-level names used by callers to tie off clear/stall.
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic TRUE    = 1'b1;
    localparam logic FALSE   = 1'b0;

    // Widest register the primitive is expected to build.
    localparam int unsigned MAX_DATA_WIDTH = 1024;

endpackage : dff_pkg

// File: rtl/dff.sv
// Parameterised D flip-flop: async active-low reset, sync clear, stall/hold.
module dff
    import dff_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH = 1,
    parameter logic [MAX_DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    // Reset/clear value sized to the register; upper bits are discarded.
    localparam logic [DATA_WIDTH-1:0] INIT_Q = INIT_VALUE[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] q_d;

    // Next value: clear beats stall, stall holds, otherwise take d.
    always_comb begin
        q_d = q_q;
        if (clear == ENABLE) begin
            q_d = INIT_Q;
        end else if (stall == DISABLE) begin
            q_d = d;
        end
    end

    // Storage; reset forces the init value independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= INIT_Q;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

`ifndef SYNTHESIS
    logic [DATA_WIDTH-1:0] ref_q;

    // Reference register built from the clear/stall/d rules, one cycle behind the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= INIT_Q;
        end else if (clear === ENABLE) begin
            ref_q <= INIT_Q;
        end else if (stall === ENABLE) begin
            ref_q <= ref_q;
        end else begin
            ref_q <= d;
        end
    end

    // Mid-cycle check that storage matches the reference, X included.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            assert (q === ref_q);
        end
    end

    // Control inputs must be known whenever the register is out of reset.
    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            assert (!$isunknown({clear, stall}));
        end
    end
`endif

endmodule : dff

// File: tb/tb_dff.sv
// Self-checking bench for dff: 8-bit instance (init A5) and 1-bit FSM-state instance.
module tb_dff;

    localparam logic [7:0] INIT8 = 8'hA5;
    localparam logic       INIT1 = 1'b0;

    logic       clk;
    logic       rst_n;
    logic       clear8;
    logic       stall8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic       clear1;
    logic       stall1;
    logic       d1;
    logic       q1;

    int n_cmp;
    int n_bad;

    // Behavioural expectations of what each register holds.
    logic [7:0] model8;
    logic       model1;

    dff #(.DATA_WIDTH(8), .INIT_VALUE(1024'hA5)) u_dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear8),
        .stall(stall8),
        .d    (d8),
        .q    (q8)
    );

    dff #(.DATA_WIDTH(1), .INIT_VALUE('0)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear1),
        .stall(stall1),
        .d    (d1),
        .q    (q1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register rule: clear wins, stall holds, else the new value is taken.
    function automatic logic [7:0] next8(input logic c, input logic s,
                                         input logic [7:0] cur, input logic [7:0] dv);
        if (c) return INIT8;
        if (s) return cur;
        return dv;
    endfunction

    // One clock: apply inputs, let the edge happen, then check both registers.
    task automatic tick(input string name, input logic c, input logic s,
                        input logic [7:0] dv, input logic dv1);
        clear8 = c;
        stall8 = s;
        d8     = dv;
        d1     = dv1;
        @(posedge clk);
        #1;
        model8 = next8(c, s, model8, dv);
        model1 = dv1;
        n_cmp++;
        if (q8 !== model8) begin
            n_bad++;
            $display("FAIL %s: q8=%h expected=%h", name, q8, model8);
        end
        n_cmp++;
        if (q1 !== model1) begin
            n_bad++;
            $display("FAIL %s: q1=%b expected=%b", name, q1, model1);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        clear8 = 1'b0;
        stall8 = 1'b0;
        d8     = 8'h3C;
        clear1 = 1'b0;
        stall1 = 1'b0;
        d1     = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (q8 !== INIT8) begin
            n_bad++;
            $display("FAIL reset_immediate: q8=%h expected=%h", q8, INIT8);
        end
        n_cmp++;
        if (q1 !== INIT1) begin
            n_bad++;
            $display("FAIL reset_immediate_1b: q1=%b expected=%b", q1, INIT1);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++;
        if (q8 !== INIT8) begin
            n_bad++;
            $display("FAIL reset_hold: q8=%h expected=%h", q8, INIT8);
        end
        #2;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (q8 !== INIT8) begin
            n_bad++;
            $display("FAIL reset_release_no_edge: q8=%h expected=%h", q8, INIT8);
        end
        model8 = INIT8;
        model1 = INIT1;
        d1     = 1'b0;
        @(posedge clk);
        #1;
        model8 = 8'h3C;
        model1 = 1'b0;
        n_cmp++;
        if (q8 !== 8'h3C) begin
            n_bad++;
            $display("FAIL reset_first_edge: q8=%h expected=%h", q8, 8'h3C);
        end
        n_cmp++;
        if (q1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_first_edge_1b: q1=%b expected=%b", q1, 1'b0);
        end
    endtask

    task automatic test_pass_through();
        tick("pass_01", 1'b0, 1'b0, 8'h01, 1'b0);
        tick("pass_02", 1'b0, 1'b0, 8'h02, 1'b0);
        tick("pass_03", 1'b0, 1'b0, 8'h03, 1'b0);
    endtask

    task automatic test_stall();
        tick("stall_load", 1'b0, 1'b0, 8'h11, 1'b0);
        for (int i = 0; i < 3; i++) tick("stall_hold", 1'b0, 1'b1, 8'h22, 1'b0);
        tick("stall_release", 1'b0, 1'b0, 8'h22, 1'b0);
    endtask

    task automatic test_clear_priority();
        tick("clear_load", 1'b0, 1'b0, 8'h55, 1'b0);
        tick("clear_over_stall", 1'b1, 1'b1, 8'hFF, 1'b0);
        tick("clear_after", 1'b0, 1'b0, 8'hFF, 1'b0);
    endtask

    task automatic test_fsm();
        tick("fsm_busy", 1'b0, 1'b0, 8'h00, 1'b1);
        tick("fsm_busy2", 1'b0, 1'b0, 8'h00, 1'b1);
        tick("fsm_idle", 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_x_propagate();
        tick("x_propagate", 1'b0, 1'b0, 8'hxx, 1'b0);
        tick("x_recover", 1'b0, 1'b0, 8'h6E, 1'b0);
    endtask

    task automatic test_random_with_reset();
        int pulse_at;
        pulse_at = 20 + int'($urandom_range(0, 10));
        for (int i = 0; i < 50; i++) begin
            if (i == pulse_at) begin
                // Pulse reset between edges; anything in flight is lost.
                #1;
                rst_n = 1'b0;
                #1;
                n_cmp++;
                if (q8 !== INIT8 || q1 !== INIT1) begin
                    n_bad++;
                    $display("FAIL midop_reset: q8=%h q1=%b expected=%h/%b", q8, q1, INIT8, INIT1);
                end
                #1;
                rst_n  = 1'b1;
                model8 = INIT8;
                model1 = INIT1;
            end
            tick("random", ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                 8'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        model8 = INIT8;
        model1 = INIT1;
        test_reset();
        test_pass_through();
        test_stall();
        test_clear_priority();
        test_fsm();
        test_x_propagate();
        test_random_with_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dff
